// File: rtl/progmem_arbiter_if.sv
// Avalon-MM master port bundle for progmem_arbiter; one instance per master.
`default_nettype none

interface progmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/progmem_arbiter.sv
// progmem_arbiter: round-robin two-master arbiter in front of a single-port program RAM.
// Optional macro PROGMEM_ARB_OUTREG_EN adds a read-data register stage (2-cycle read latency).
`default_nettype none

module progmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,
  progmem_arbiter_if.slave    m0,
  progmem_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                arb_busy
);

  logic              req0, req1;
  logic              grant0, grant1;
  logic              rd_accept;
  logic              last_grant_d, last_grant_q;
  logic              rd_valid_d, rd_valid_q;
  logic              rd_owner_d, rd_owner_q;
  logic              ret_valid, ret_owner;
  logic [DATA_W-1:0] ret_data;

  // Grants are masked by reset_n so the RAM sees no strobe while reset is held.
  always_comb begin
    req0         = m0.read | m0.write;
    req1         = m1.read | m1.write;
    grant0       = 1'b0;
    grant1       = 1'b0;
    if (reset_n && !freeze) begin
      if (req0 && req1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;
    // A simultaneous read+write is treated as a write only.
    rd_accept  = (grant0 & m0.read & ~m0.write) | (grant1 & m1.read & ~m1.write);
    rd_valid_d = rd_accept;
    rd_owner_d = grant1;
  end

  always_comb begin
    mem_chipselect = grant0 | grant1;
    if (grant1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
    end else begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_write      = m0.write & grant0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

`ifdef PROGMEM_ARB_OUTREG_EN
  logic              rd_valid2_d, rd_valid2_q;
  logic              rd_owner2_d, rd_owner2_q;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_valid2_d = rd_valid_q;
    rd_owner2_d = rd_owner_q;
    rd_data_d   = rd_valid_q ? mem_readdata : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid2_q <= 1'b0;
      rd_owner2_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid2_q <= rd_valid2_d;
      rd_owner2_q <= rd_owner2_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign ret_valid = rd_valid2_q;
  assign ret_owner = rd_owner2_q;
  assign ret_data  = rd_data_q;
  assign arb_busy  = mem_chipselect | rd_valid_q | rd_valid2_q;
`else
  assign ret_valid = rd_valid_q;
  assign ret_owner = rd_owner_q;
  assign ret_data  = mem_readdata;
  assign arb_busy  = mem_chipselect | rd_valid_q;
`endif

  assign mem_clken        = reset_n;
  assign m0.waitrequest   = req0 & ~grant0;
  assign m1.waitrequest   = req1 & ~grant1;
  assign m0.readdata      = ret_data;
  assign m1.readdata      = ret_data;
  assign m0.readdatavalid = ret_valid & ~ret_owner;
  assign m1.readdatavalid = ret_valid & ret_owner;

endmodule

`default_nettype wire

// File: tb/tb_progmem_arbiter.sv
// Self-checking bench for progmem_arbiter: directed scenarios then randomized traffic against a reference model.
`default_nettype none

module tb_progmem_arbiter;
`ifdef PROGMEM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, arb_busy;
  logic [31:0] mem_writedata, mem_readdata, ram_q;

  progmem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) m0_if ();
  progmem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) m1_if ();

  progmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .m0(m0_if), .m1(m1_if),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with registered read port.
  logic [31:0] ram [0:16383];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] = merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  // Reference model state
  typedef struct { int due; int owner; logic [31:0] data; } pend_t;
  pend_t       pq[$];
  logic [31:0] ref_mem [0:16383];
  int          last_g, cyc, granted;
  int          nassert = 0, nfail = 0;
  int          v0cnt = 0, v1cnt = 0;
  logic [31:0] last_d0, last_d1;

  // Per-master requests held by the bench until granted
  logic        rd [2], wr [2];
  logic [13:0] ad [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin rd[i] = 0; wr[i] = 0; end
  endtask

  task automatic model_reset();
    pq.delete();
    last_g = 1;
  endtask

  // One clock: apply inputs, check every output against the model, advance the model at the edge.
  task automatic cycle();
    logic rq [2];
    int   g;
    logic ev [2];
    logic [31:0] ed;
    logic busy;
    m0_if.read = rd[0]; m0_if.write = wr[0]; m0_if.address = ad[0]; m0_if.byteenable = be[0]; m0_if.writedata = wd[0];
    m1_if.read = rd[1]; m1_if.write = wr[1]; m1_if.address = ad[1]; m1_if.byteenable = be[1]; m1_if.writedata = wd[1];
    #1;
    rq[0] = rd[0] | wr[0];
    rq[1] = rd[1] | wr[1];
    g = -1;
    if (reset_n && !freeze) begin
      if (rq[0] && rq[1]) g = 1 - last_g;
      else if (rq[0])     g = 0;
      else if (rq[1])     g = 1;
    end
    ev[0] = 0; ev[1] = 0; ed = '0; busy = (g >= 0);
    foreach (pq[k]) begin
      if (pq[k].due == cyc) begin ev[pq[k].owner] = 1; ed = pq[k].data; end
      if (pq[k].due >= cyc) busy = 1;
    end
    chk("wait0", m0_if.waitrequest, rq[0] && g != 0);
    chk("wait1", m1_if.waitrequest, rq[1] && g != 1);
    chk("chipselect", mem_chipselect, g >= 0);
    chk("mem_write", mem_write, g >= 0 && wr[g]);
    if (g >= 0) chk("mem_bus", {mem_address, mem_byteenable, mem_writedata}, {ad[g], be[g], wd[g]});
    chk("clken", mem_clken, reset_n);
    chk("busy", arb_busy, busy);
    chk("rdv0", m0_if.readdatavalid, ev[0]);
    chk("rdv1", m1_if.readdatavalid, ev[1]);
    if (ev[0]) chk("rdata0", m0_if.readdata, ed);
    if (ev[1]) chk("rdata1", m1_if.readdata, ed);
    if (m0_if.readdatavalid) begin v0cnt++; last_d0 = m0_if.readdata; end
    if (m1_if.readdatavalid) begin v1cnt++; last_d1 = m1_if.readdata; end
    @(posedge clk);
    if (reset_n && g >= 0) begin
      last_g = g;
      if (wr[g])      ref_mem[ad[g]] = merge(ref_mem[ad[g]], wd[g], be[g]);
      else if (rd[g]) pq.push_back('{cyc + LAT, g, ref_mem[ad[g]]});
    end
    granted = g;
    cyc++;
    while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
    @(negedge clk);
  endtask

  int s0, s1;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = i * 32'h9E3779B1;
      ref_mem[i] = ram[i];
    end
    ram[14'h0010] = 32'hDEADBEEF; ref_mem[14'h0010] = 32'hDEADBEEF;
    ram[14'h3FFF] = 32'hAAAAAAAA; ref_mem[14'h3FFF] = 32'hAAAAAAAA;
    for (int i = 0; i < 2; i++) begin ad[i] = 0; be[i] = 4'hF; wd[i] = 0; end
    clr();
    freeze = 0; cyc = 0; granted = -1; last_d0 = '0; last_d1 = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    // Reset state, including a requester that must not be granted
    rd[0] = 1; ad[0] = 14'h0010;
    cycle(); cycle();
    clr();
    reset_n = 1'b1;

    // Single read
    rd[0] = 1; ad[0] = 14'h0010;
    cycle(); clr();
    s1 = v1cnt;
    for (int i = 0; i < LAT; i++) cycle();
    chk("single_data", last_d0, 32'hDEADBEEF);
    chk("single_no_m1", v1cnt - s1, 0);

    // Contention: both masters read continuously
    s0 = v0cnt; s1 = v1cnt;
    rd[0] = 1; ad[0] = 14'h0100; rd[1] = 1; ad[1] = 14'h0200;
    for (int i = 0; i < 8; i++) cycle();
    clr();
    for (int i = 0; i < LAT; i++) cycle();
    chk("cont_v0", v0cnt - s0, 4);
    chk("cont_v1", v1cnt - s1, 4);

    // Partial write then read-back
    wr[1] = 1; ad[1] = 14'h3FFF; be[1] = 4'b0011; wd[1] = 32'h12345678;
    cycle(); clr();
    rd[0] = 1; ad[0] = 14'h3FFF;
    cycle(); clr();
    for (int i = 0; i < LAT; i++) cycle();
    chk("wr_rd_data", last_d0, 32'hAAAA5678);

    // Read and write together on m0
    s0 = v0cnt;
    rd[0] = 1; wr[0] = 1; ad[0] = 14'h0004; be[0] = 4'hF; wd[0] = 32'hCAFEF00D;
    cycle(); clr();
    for (int i = 0; i < LAT + 1; i++) cycle();
    chk("rw_no_valid", v0cnt - s0, 0);

    // Freeze with a read accepted just before it rises
    s0 = v0cnt;
    rd[0] = 1; ad[0] = 14'h0010;
    cycle(); clr();
    freeze = 1; rd[1] = 1; ad[1] = 14'h0020;
    for (int i = 0; i < 5; i++) cycle();
    chk("freeze_ret", v0cnt - s0, 1);
    freeze = 0;
    cycle();
    chk("freeze_grant", granted, 1);
    clr();
    for (int i = 0; i < LAT; i++) cycle();

    // Reset one cycle after a read is accepted
    rd[0] = 1; ad[0] = 14'h0010;
    cycle(); clr();
    reset_n = 1'b0; model_reset();
    cycle(); cycle();
    reset_n = 1'b1;
    rd[0] = 1; rd[1] = 1; ad[0] = 14'h0030; ad[1] = 14'h0040;
    cycle();
    chk("post_reset_win", granted, 0);
    clr();
    for (int i = 0; i < LAT + 1; i++) cycle();

    // Randomized traffic on a small address window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(rd[i] || wr[i]) && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0, 1:    begin rd[i] = 1; wr[i] = 0; end
            2, 3:    begin rd[i] = 0; wr[i] = 1; end
            default: begin rd[i] = 1; wr[i] = 1; end
          endcase
          ad[i] = $urandom_range(0, 1) ? 14'($urandom_range(0, 7)) : 14'(16376 + $urandom_range(0, 7));
          be[i] = 4'($urandom_range(0, 15));
          wd[i] = $urandom;
        end
      end
      freeze = ($urandom_range(0, 7) == 0);
      cycle();
      if (granted >= 0) begin rd[granted] = 0; wr[granted] = 0; end
    end
    clr(); freeze = 0;
    for (int i = 0; i < LAT + 1; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

`default_nettype wire
